gnrl_iq_boxcar_decim: RTL and testbench
=======================================

GNRL_IQ_BOXCAR_DECIM -- requirements
Module: gnrl_iq_boxcar_decim

Interface
REQ-001 The block SHALL have parameter IN_WIDTH, default 15: width of the signed I/Q inputs (ADC_PHYS_WIDTH+1).
REQ-002 The block SHALL have parameter ACC_WIDTH, default 32: accumulator and output width, and ACC_WIDTH SHALL be at least IN_WIDTH+DEC_WIDTH.
REQ-003 The block SHALL have parameter DEC_WIDTH, default 16: width of the decimation factor.
REQ-004 The block SHALL have port CLK, input, 1 bit: the single system clock, with all state updating on its rising edge.
REQ-005 The block SHALL have port RESET, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have ports data_i and data_q, inputs, IN_WIDTH bits each: signed in-phase and quadrature samples from the downconverter.
REQ-007 The block SHALL have port conv_en, input, 1 bit: a sample is valid on every CLK edge where conv_en is high.
REQ-008 The block SHALL have port dec_factor, input, DEC_WIDTH bits: number of samples summed per output.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result when out_ready and out_valid are both high.
REQ-010 The block SHALL have port clr_ovf, input, 1 bit: synchronous clear of ovf.
REQ-011 The block SHALL have ports acc_i and acc_q, outputs, ACC_WIDTH bits each: signed boxcar sums.
REQ-012 The block SHALL have port out_valid, output, 1 bit: acc_i and acc_q hold an unconsumed result.
REQ-013 The block SHALL have port ovf, output, 1 bit: sticky flag meaning at least one result was dropped.
REQ-014 The block SHALL have port out_count, output, 16 bits: number of results produced since reset.
REQ-015 The block SHALL have port busy, output, 1 bit: high while the state machine is in ACCUM.

Function
REQ-016 The state machine SHALL have two states, IDLE and ACCUM.
REQ-017 IDLE->ACCUM SHALL happen on the first edge where conv_en is high; that sample SHALL be accumulated, and dec_factor SHALL be latched on the same edge.
REQ-018 A latched dec_factor of 0 SHALL be treated as 1.
REQ-019 Changes to dec_factor while in ACCUM SHALL be ignored until the next IDLE->ACCUM transition.
REQ-020 In ACCUM, on every edge with conv_en high, the block SHALL add sign-extended data_i and data_q to the internal sums and increment the sample counter.
REQ-021 Sums SHALL wrap modulo 2^ACC_WIDTH, with no saturation.
REQ-022 Dump: on the edge that accepts sample number D (D = latched factor), the block SHALL:
- load acc_i/acc_q with the running sum plus that sample;
- zero the internal sums and counter on the same edge;
- continue in ACCUM with no gap cycle.
REQ-023 out_valid SHALL rise on the edge after the D-th sample is presented, giving latency 1 cycle from the last input sample to output.
REQ-024 out_valid SHALL fall on the edge where out_valid and out_ready are both high, unless a dump occurs on the same edge, in which case the new result SHALL load and out_valid SHALL stay high.
REQ-025 If a dump occurs while out_valid is high and out_ready is low:
- the new result SHALL be discarded;
- acc_i/acc_q SHALL keep the old result;
- ovf SHALL be set;
- out_count SHALL NOT increment.
REQ-026 out_count SHALL increment on each dump that loads acc_i/acc_q, and SHALL wrap from 65535 to 0.
REQ-027 ovf SHALL clear on the edge where clr_ovf is high; if clr_ovf is high on the same edge as a drop, ovf SHALL be set (set wins).
REQ-028 When conv_en is low in ACCUM, the block SHALL:
- go to IDLE;
- discard the partial sum;
- clear the counter;
- leave out_valid, acc_i, acc_q and out_count unchanged.
REQ-029 On re-entry to ACCUM, accumulation SHALL start from zero with a freshly latched dec_factor.

Reset
REQ-030 RESET high SHALL asynchronously force:
- state to IDLE;
- internal sums and counter to 0;
- acc_i and acc_q to 0;
- out_valid, ovf and busy to 0;
- out_count to 0.
REQ-031 After RESET deasserts, the first accumulated sample SHALL be the first edge with conv_en high.
REQ-032 RESET asserted mid-block SHALL discard the partial sum and any pending result.

Verification
REQ-033 Basic dump: dec_factor=4, data_i=100, data_q=-50 held, conv_en high, out_ready high -> a one-cycle out_valid pulse every 4 cycles with acc_i=400 and acc_q=-200; out_count increments by 1 per pulse.
REQ-034 Backpressure: dec_factor=2, out_ready low for 5 cycles -> first result held; subsequent dumps dropped; ovf=1; out_count=1. Then clr_ovf pulse -> ovf=0.
REQ-035 Abort: dec_factor=8, conv_en high for 5 samples of 10 then low, then high for 8 samples of 1 -> a single output with acc_i=8 (the partial sum of 50 is discarded).
REQ-036 Edge values: dec_factor=0 -> one output per sample equal to the input; data_i=-16384 with dec_factor=65535 -> acc_i=-1073725440, with no wrap.
REQ-037 Reset mid-operation: RESET asserted asynchronously (between clock edges) with out_valid=1 and 3 samples accumulated -> all outputs 0 immediately, with no CLK edge required.
REQ-038 Simultaneous handshake: dec_factor=1, out_ready high continuously -> out_valid stays high every cycle, acc_i tracks data_i delayed by 1 cycle, and ovf stays 0.

Source files
------------

// File: rtl/gnrl_iq_boxcar_decim.sv
// gnrl_iq_boxcar_decim: boxcar-sums D signed I/Q samples per output with a one-deep
// valid/ready result register; results that arrive while it is still full are dropped.
module gnrl_iq_boxcar_decim #(
    parameter int IN_WIDTH  = 15,
    parameter int ACC_WIDTH = 32,
    parameter int DEC_WIDTH = 16
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic signed [IN_WIDTH-1:0]  data_i,
    input  logic signed [IN_WIDTH-1:0]  data_q,
    input  logic                        conv_en,
    input  logic [DEC_WIDTH-1:0]        dec_factor,
    input  logic                        out_ready,
    input  logic                        clr_ovf,
    output logic signed [ACC_WIDTH-1:0] acc_i,
    output logic signed [ACC_WIDTH-1:0] acc_q,
    output logic                        out_valid,
    output logic                        ovf,
    output logic [15:0]                 out_count,
    output logic                        busy
);
    typedef enum logic {IDLE, ACCUM} state_t;
    state_t state;
    logic signed [ACC_WIDTH-1:0] sum_i, sum_q, nxt_i, nxt_q;
    logic [DEC_WIDTH-1:0] cnt, dec, dec_eff, nxt_cnt;
    logic dump, take;
    // In IDLE the incoming sample starts a fresh block, so the factor and sums come from scratch
    always_comb begin
        dec_eff = state == ACCUM ? dec : (dec_factor == '0 ? DEC_WIDTH'(1) : dec_factor);
        nxt_i   = (state == ACCUM ? sum_i : '0) + ACC_WIDTH'(data_i);
        nxt_q   = (state == ACCUM ? sum_q : '0) + ACC_WIDTH'(data_q);
        nxt_cnt = (state == ACCUM ? cnt : '0) + DEC_WIDTH'(1);
        dump    = conv_en && nxt_cnt == dec_eff;
        take    = dump && (!out_valid || out_ready);
    end
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= IDLE;
            busy      <= 1'b0;
            dec       <= '0;
            cnt       <= '0;
            sum_i     <= '0;
            sum_q     <= '0;
            acc_i     <= '0;
            acc_q     <= '0;
            out_valid <= 1'b0;
            ovf       <= 1'b0;
            out_count <= '0;
        end else begin
            state <= conv_en ? ACCUM : IDLE;
            busy  <= conv_en;
            if (conv_en && state == IDLE)
                dec <= dec_eff;
            sum_i <= conv_en && !dump ? nxt_i : '0;
            sum_q <= conv_en && !dump ? nxt_q : '0;
            cnt   <= conv_en && !dump ? nxt_cnt : '0;
            if (take) begin
                acc_i     <= nxt_i;
                acc_q     <= nxt_q;
                out_valid <= 1'b1;
                out_count <= out_count + 16'd1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            ovf <= (dump && !take) || (ovf && !clr_ovf);
        end
    end
endmodule

// File: tb/tb_gnrl_iq_boxcar_decim.sv
// tb_gnrl_iq_boxcar_decim: random and directed stimulus against a sample-list reference
// model; expected results are queued and popped by a monitor on each output handshake.
module tb_gnrl_iq_boxcar_decim;
    logic CLK = 1'b0;
    logic RESET = 1'b1;
    logic signed [14:0] data_i = '0, data_q = '0;
    logic conv_en = 1'b0, out_ready = 1'b0, clr_ovf = 1'b0;
    logic [15:0] dec_factor = '0;
    logic signed [31:0] acc_i, acc_q;
    logic out_valid, ovf, busy;
    logic [15:0] out_count;

    gnrl_iq_boxcar_decim dut (
        .CLK(CLK), .RESET(RESET), .data_i(data_i), .data_q(data_q), .conv_en(conv_en),
        .dec_factor(dec_factor), .out_ready(out_ready), .clr_ovf(clr_ovf),
        .acc_i(acc_i), .acc_q(acc_q), .out_valid(out_valid), .ovf(ovf),
        .out_count(out_count), .busy(busy)
    );

    always #5 CLK = ~CLK;

    int tests = 0, fails = 0;
    bit running = 0;

    // Reference model: the samples of the current block are kept as lists and summed on dump
    int blk_i[$], blk_q[$];
    bit m_inblk = 0, m_valid = 0, m_ovf = 0;
    int m_d = 1, m_cnt = 0;
    logic [31:0] exp_i[$], exp_q[$];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    task automatic model_reset();
        blk_i.delete(); blk_q.delete(); exp_i.delete(); exp_q.delete();
        m_inblk = 0; m_valid = 0; m_ovf = 0; m_d = 1; m_cnt = 0;
    endtask

    task automatic apply(bit ce, int di, int dq, int df, bit rdy, bit clr);
        longint si, sq;
        bit drop = 0;
        if (m_valid && rdy) m_valid = 0;
        if (ce) begin
            if (!m_inblk) begin
                m_inblk = 1;
                m_d = (df == 0) ? 1 : df;
                blk_i.delete(); blk_q.delete();
            end
            blk_i.push_back(di); blk_q.push_back(dq);
            if (blk_i.size() == m_d) begin
                if (!m_valid) begin
                    si = 0; sq = 0;
                    foreach (blk_i[k]) begin si += blk_i[k]; sq += blk_q[k]; end
                    exp_i.push_back(si[31:0]); exp_q.push_back(sq[31:0]);
                    m_valid = 1;
                    m_cnt = (m_cnt + 1) % 65536;
                end else drop = 1;
                blk_i.delete(); blk_q.delete();
            end
        end else begin
            m_inblk = 0;
            blk_i.delete(); blk_q.delete();
        end
        m_ovf = drop ? 1'b1 : (clr ? 1'b0 : m_ovf);
    endtask

    task automatic step(bit ce, int di, int dq, int df, bit rdy, bit clr);
        conv_en = ce; data_i = 15'(di); data_q = 15'(dq);
        dec_factor = 16'(df); out_ready = rdy; clr_ovf = clr;
        @(posedge CLK);
        #1;
        apply(ce, di, dq, df, rdy, clr);
    endtask

    function automatic int rnd_sample();
        return int'($urandom_range(0, 32767)) - 16384;
    endfunction

    always @(negedge CLK) begin
        if (running && !RESET) begin
            chk("out_valid", 32'(out_valid), 32'(m_valid));
            chk("out_count", 32'(out_count), 32'(m_cnt));
            chk("ovf", 32'(ovf), 32'(m_ovf));
            chk("busy", 32'(busy), 32'(m_inblk));
            if (out_valid && out_ready) begin
                if (exp_i.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL handshake: got result %0d/%0d expected no result pending", acc_i, acc_q);
                end else begin
                    chk("acc_i", acc_i, exp_i.pop_front());
                    chk("acc_q", acc_q, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #3;
        chk("reset acc_i", acc_i, 32'd0);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset out_count", 32'(out_count), 32'd0);
        @(posedge CLK); #1;
        RESET = 1'b0;
        running = 1;
        // Basic dump: 400 / -200 every four samples
        for (int n = 0; n < 12; n++) step(1, 100, -50, 4, 1, 0);
        chk("basic acc_i", acc_i, 32'd400);
        chk("basic acc_q", acc_q, -32'sd200);
        chk("basic count", 32'(out_count), 32'd3);
        step(0, 0, 0, 4, 1, 0);
        step(0, 0, 0, 4, 1, 0);
        // Backpressure: first result held, later dumps dropped
        for (int n = 0; n < 6; n++) step(1, 7, 3, 2, 0, 0);
        chk("bp ovf", 32'(ovf), 32'd1);
        chk("bp acc_i", acc_i, 32'd14);
        chk("bp count", 32'(out_count), 32'd4);
        step(0, 0, 0, 2, 1, 1);
        chk("clr ovf", 32'(ovf), 32'd0);
        // Abort discards the partial block
        for (int n = 0; n < 5; n++) step(1, 10, 10, 8, 1, 0);
        step(0, 0, 0, 8, 1, 0);
        for (int n = 0; n < 8; n++) step(1, 1, 1, 8, 0, 0);
        chk("abort acc_i", acc_i, 32'd8);
        step(0, 0, 0, 8, 1, 0);
        // Factor 0 behaves as 1: continuous one-per-cycle output
        for (int n = 0; n < 40; n++) step(1, rnd_sample(), rnd_sample(), 0, 1, 0);
        chk("df0 ovf", 32'(ovf), 32'd0);
        step(0, 0, 0, 0, 1, 0);
        // Largest factor with most negative input
        for (int n = 0; n < 65535; n++) step(1, -16384, 16383, 65535, 1, 0);
        chk("max acc_i", acc_i, -32'sd1073725440);
        chk("max acc_q", acc_q, 32'sd1073659905);
        step(0, 0, 0, 1, 1, 0);
        // Random mix of enables, factors, backpressure and clears
        for (int n = 0; n < 3000; n++)
            step($urandom_range(0, 19) != 0, rnd_sample(), rnd_sample(), int'($urandom_range(0, 5)),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
        // Asynchronous reset with a held result and three samples accumulated
        step(0, 0, 0, 4, 0, 0);
        for (int n = 0; n < 7; n++) step(1, 5, -5, 4, 0, 0);
        chk("pre-reset valid", 32'(out_valid), 32'd1);
        #2;
        RESET = 1'b1;
        #1;
        chk("async acc_i", acc_i, 32'd0);
        chk("async acc_q", acc_q, 32'd0);
        chk("async valid", 32'(out_valid), 32'd0);
        chk("async count", 32'(out_count), 32'd0);
        chk("async busy", 32'(busy), 32'd0);
        conv_en = 0; out_ready = 0;
        model_reset();
        @(posedge CLK); #1;
        RESET = 1'b0;
        for (int n = 0; n < 6; n++) step(1, 9, 2, 3, 1, 0);
        chk("post-reset acc_i", acc_i, 32'd27);
        step(0, 0, 0, 3, 1, 0);
        step(0, 0, 0, 3, 1, 0);
        chk("drained", 32'(exp_i.size()), 32'd0);
        running = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
